// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and FSM encoding for the PC generation stage
package pc_gen_pkg;
  localparam int PC_ADDR_WIDTH = 32;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam int PC_STEP = 4;
  typedef enum logic [1:0] {
    PC_ST_BOOT = 2'd0,
    PC_ST_RUN  = 2'd1,
    PC_ST_HALT = 2'd2
  } pc_state_e;
endpackage

// File: rtl/pc_redirect_mux.sv
// pc_redirect_mux: next-PC priority select; PC_MISALIGN_CHECK_EN rejects unaligned targets instead of masking
module pc_redirect_mux
  import pc_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_ADDR_WIDTH
) (
  input  pc_state_e             state,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
`ifdef PC_MISALIGN_CHECK_EN
  output logic                  misalign,
`endif
  output logic [ADDR_WIDTH-1:0] next_pc
);
  logic [ADDR_WIDTH-1:0] target;
  logic bad;
  logic take;
`ifdef PC_MISALIGN_CHECK_EN
  assign bad = redirect && state != PC_ST_BOOT && redirect_pc[1:0] != 2'b00;
  assign target = redirect_pc;
  assign misalign = bad;
`else
  assign bad = 1'b0;
  assign target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
`endif
  assign take = redirect && state != PC_ST_BOOT && !bad;
  assign next_pc = take ? target : (state == PC_ST_RUN && !halt && !stall) ? pc_plus4 : pc;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with boot window, halt/resume FSM and redirects; optional PC_MISALIGN_CHECK_EN
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = PC_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(PC_RESET_DEF),
  parameter int                    BOOT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  input  logic                  resume_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
`ifdef PC_MISALIGN_CHECK_EN
  output logic                  misalign_o,
`endif
  output logic                  pc_valid_o
);
  pc_state_e state, state_n;
  logic [3:0] cnt;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic bad;
  assign pc_plus4_o = pc_o + ADDR_WIDTH'(PC_STEP);
  assign pc_valid_o = state == PC_ST_RUN;
  pc_redirect_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_mux (
    .state      (state),
    .pc         (pc_o),
    .pc_plus4   (pc_plus4_o),
    .stall      (stall_i),
    .redirect   (redirect_i),
    .redirect_pc(redirect_pc_i),
    .halt       (halt_i),
`ifdef PC_MISALIGN_CHECK_EN
    .misalign   (bad),
`endif
    .next_pc    (next_pc)
  );
`ifndef PC_MISALIGN_CHECK_EN
  assign bad = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      PC_ST_BOOT: state_n = cnt == 4'(BOOT_CYCLES - 1) ? PC_ST_RUN : PC_ST_BOOT;
      PC_ST_RUN:  state_n = (bad || halt_i) ? PC_ST_HALT : PC_ST_RUN;
      PC_ST_HALT: state_n = (!bad && resume_i) ? PC_ST_RUN : PC_ST_HALT;
      default:    state_n = PC_ST_BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PC_ST_BOOT;
      pc_o  <= RESET_PC;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      pc_o  <= next_pc;
      cnt   <= state == PC_ST_BOOT ? cnt + 4'd1 : cnt;
    end
  end
`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_o <= 1'b0;
    else misalign_o <= bad;
  end
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen against a behavioural PC/halt/boot model
module tb_pc_gen;
  localparam logic [31:0] RPC = 32'h100;
  localparam int BOOT = 2;
  logic clk = 0;
  logic rst = 1, stall_i = 0, redirect_i = 0, halt_i = 0, resume_i = 0;
  logic [31:0] redirect_pc_i = 0;
  logic [31:0] pc_o, pc_plus4_o;
  logic pc_valid_o;
`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_o;
`endif
  always #5 clk = ~clk;
  pc_gen #(.ADDR_WIDTH(32), .RESET_PC(RPC), .BOOT_CYCLES(BOOT)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halt_i       (halt_i),
    .resume_i     (resume_i),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
`ifdef PC_MISALIGN_CHECK_EN
    .misalign_o   (misalign_o),
`endif
    .pc_valid_o   (pc_valid_o)
  );
  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        m;
  } exp_t;
  exp_t q[$];
  int checks = 0, passed = 0;
  logic [31:0] m_pc;
  int m_boot;
  logic m_halt, m_mis;
  task automatic cyc(input logic r, s, d, input logic [31:0] t, input logic h, u);
    logic bad;
    @(negedge clk);
    rst = r; stall_i = s; redirect_i = d; redirect_pc_i = t; halt_i = h; resume_i = u;
    if (r) begin
      m_pc = RPC; m_boot = BOOT; m_halt = 0; m_mis = 0;
    end else if (m_boot > 0) begin
      m_boot--; m_mis = 0;
    end else begin
      bad = 0;
`ifdef PC_MISALIGN_CHECK_EN
      bad = d && t[1:0] != 2'b00;
`endif
      m_mis = bad;
      if (bad) m_halt = 1;
      else if (m_halt) begin
        if (d) m_pc = t & ~32'h3;
        if (u) m_halt = 0;
      end else if (d) begin
        m_pc = t & ~32'h3;
        if (h) m_halt = 1;
      end else if (h) m_halt = 1;
      else if (!s) m_pc = m_pc + 32'd4;
    end
    q.push_back('{m_pc, (m_boot == 0) && !m_halt, m_mis});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    exp_t e;
    logic mis_act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        mis_act = e.m;
`ifdef PC_MISALIGN_CHECK_EN
        mis_act = misalign_o;
`endif
        checks++;
        if (pc_o !== e.pc || pc_plus4_o !== e.pc + 32'd4 || pc_valid_o !== e.v || mis_act !== e.m)
          $display("FAIL cycle_out t=%0t: pc=%h p4=%h valid=%b mis=%b, required pc=%h p4=%h valid=%b mis=%b",
                   $time, pc_o, pc_plus4_o, pc_valid_o, mis_act, e.pc, e.pc + 32'd4, e.v, e.m);
        else passed++;
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    idle(5);
    cyc(0, 0, 1, 32'h200, 0, 0);
    idle(1);
    cyc(0, 0, 1, 32'h80, 0, 0);
    idle(2);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle(3);
    cyc(0, 0, 1, 32'h40, 0, 0);
    cyc(0, 1, 1, 32'h400, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h300, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 32'h500, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(0, 0, 1, 32'h10, 0, 0);
    cyc(0, 0, 1, 32'h202, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(0, 0, 1, 32'h600, 1, 0);
    cyc(0, 0, 1, 32'h700, 0, 1);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(4);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h900, 1, 1);
    cyc(0, 1, 1, 32'h904, 1, 1);
    idle(4);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom;
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end
    idle(1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) $display("FAIL drain: %0d entries left, required 0", q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage of the core, sitting directly upstream of instruction fetch. Holds the architectural fetch PC in a register, drives it as the fetch address every cycle, and advances it by 4 or loads a redirect target. It also applies hazard stalls and halt/resume control, and masks fetch during a short post-reset boot window.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of the PC and fetch address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Must be word aligned.
- BOOT_CYCLES, 2, number of cycles after reset release with pc_valid_o low. Legal range 1..15.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- stall_i  in  1  hazard-unit hold; the PC keeps its value.
- redirect_i  in  1  jump, branch or trap taken.
- redirect_pc_i  in  ADDR_WIDTH  redirect target.
- halt_i  in  1  request to stop fetching.
- resume_i  in  1  leave HALT.
- pc_o  out  ADDR_WIDTH  registered fetch address, fed to the instruction memory address.
- pc_plus4_o  out  ADDR_WIDTH  pc_o + 4, modulo 2^ADDR_WIDTH; combinational; carried to IF/ID for link values.
- pc_valid_o  out  1  fetch at pc_o is architecturally valid.
- misalign_o  out  1  misaligned redirect detected. Present only with the macro below.

## Operation
- FSM states: BOOT, RUN, HALT. 2-bit encoding.
- Reset: state=BOOT, pc_o=RESET_PC, boot counter=0, pc_valid_o=0, misalign_o=0. A reset asserted mid-operation behaves identically, whatever the current state or inputs.
- BOOT:
  - The counter increments each cycle. When counter==BOOT_CYCLES-1, the next state is RUN.
  - All of stall_i, redirect_i, halt_i and resume_i are ignored.
  - pc_o holds RESET_PC.
- RUN uses this priority: redirect_i > halt_i > stall_i > increment.
  - redirect: pc <= target. The state stays RUN unless halt_i is also high, in which case the target is loaded and the state goes to HALT.
  - halt (no redirect): pc held, state goes to HALT.
  - stall: pc held.
  - otherwise: pc <= pc + 4. 0xFFFF_FFFC wraps to 0x0000_0000.
- HALT:
  - pc_valid_o is 0.
  - redirect_i loads the PC and the state stays HALT.
  - resume_i goes to RUN. If redirect_i and resume_i are high together, the target is loaded and the state goes to RUN.
  - halt_i and stall_i have no effect.
- pc_valid_o = (state==RUN). It is registered-state derived and glitch-free.
- Redirect target alignment, without the macro: bits [1:0] of redirect_pc_i are forced to 0.

## Timing
- pc_o is a register. A redirect sampled at edge N is visible on pc_o after edge N; the fetch of the target happens in that same cycle, because instruction memory reads combinationally.
- Redirect latency is 1 cycle. The wrong-path instruction already in IF/ID is flushed by downstream logic, not by this block.
- Sustained stall_i holds pc_o indefinitely. pc_valid_o stays 1 during a stall.
- Boot: rst is sampled high at edge E0. pc_valid_o is first 1 after edge E0+BOOT_CYCLES.
- halt_i sampled at edge N: pc_valid_o=0 after edge N.
- resume_i sampled at edge N: pc_valid_o=1 after edge N.

## Configuration
- PC_MISALIGN_CHECK_EN
  - Defined:
    - A RUN or HALT redirect with redirect_pc_i[1:0]!=0 is not loaded; pc_o holds.
    - misalign_o pulses high for exactly 1 cycle, registered, after the sampling edge. The state goes to HALT.
    - An aligned redirect behaves normally.
    - misalign_o is 0 in reset and in BOOT.
  - Not defined: the misalign_o port and its logic are absent, and the low bits of the target are silently forced to 0.

## Structure
- Shared include: ADDR_WIDTH default, RESET_PC default, PC step constant 4, and the FSM state encodings (PC_ST_BOOT=0, PC_ST_RUN=1, PC_ST_HALT=2).
- One sub-module: pc_redirect_mux.
  - It is combinational.
  - It implements the priority select of the next PC: target, hold or +4, with the alignment masking or check.
  - The FSM, boot counter and PC register stay in pc_gen.

## Test plan
- Reset, BOOT_CYCLES=2, RESET_PC=0x100: rst high 3 cycles then low -> pc_o=0x100. pc_valid_o is 0 for 2 cycles after release, then 1. pc_o then reads 0x100, 0x104, 0x108.
- Redirect and wrap:
  - Running at pc 0x200, redirect_pc_i=0x80 for one cycle -> next pc_o=0x80, then 0x84.
  - Load 0xFFFF_FFFC and run free -> pc_o goes to 0x0000_0000.
- Simultaneous events:
  - stall_i + redirect_i at pc 0x40, target 0x400 -> pc_o=0x400.
  - stall_i alone for 3 cycles -> pc_o stays 0x404 (one step after the redirect), with pc_valid_o=1.
- Halt/resume at pc 0x300:
  - halt_i -> pc_valid_o=0 and pc_o=0x300 held.
  - redirect to 0x500 while halted -> pc_o=0x500, still invalid.
  - resume_i -> valid, then 0x504.
- Misalign, with PC_MISALIGN_CHECK_EN, redirect_pc_i=0x202 at pc 0x10 -> pc_o holds 0x10, misalign_o is a 1-cycle pulse, state goes to HALT. Without the macro -> pc_o=0x200.
- Reset mid-HALT and mid-stall -> BOOT re-entered, pc_o=RESET_PC, pc_valid_o=0 for BOOT_CYCLES cycles.
